// File: rtl/loctag_nch.sv
// Multi-channel RF tag switch controller: trigger sync, trimmed delay, then static/toggle/round-robin drive.
// Optional burst watchdog with LOCKOUT state is compiled in by defining LOCTAG_WATCHDOG_EN.
module loctag_nch #(
    parameter int CLK_FREQ_MHZ           = 50,
    parameter int NUM_CH                 = 4,
    parameter int CH_W                   = 2,
    parameter int TRIG_DELAY_IN_US       = 2,
    parameter int TRIG_DELAY_IN_20NS_NEG = 25,
    parameter int DIV_W                  = 16,
    parameter int MAX_ACTIVE_US          = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [1:0]        mode,
    input  logic [CH_W-1:0]   mac_q,
    input  logic [DIV_W-1:0]  half_period,
    output logic              lt5534_en,
    output logic [NUM_CH-1:0] ctrl,
    output logic              led,
    output logic              busy
);

    localparam int D     = TRIG_DELAY_IN_US * CLK_FREQ_MHZ - TRIG_DELAY_IN_20NS_NEG;
    localparam int DLY_W = (D > 1) ? $clog2(D) : 1;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (D < 1) begin : g_bad_delay
        $error("loctag_nch: trigger delay count must be at least 1");
    end
    if (NUM_CH < 1 || NUM_CH > 16 || (1 << CH_W) < NUM_CH) begin : g_bad_ch
        $error("loctag_nch: NUM_CH must be 1..16 and fit in CH_W bits");
    end
    if (MAX_ACTIVE_US < 1) begin : g_bad_wd
        $error("loctag_nch: MAX_ACTIVE_US must be at least 1");
    end

`ifdef LOCTAG_WATCHDOG_EN
    localparam int WD    = MAX_ACTIVE_US * CLK_FREQ_MHZ;
    localparam int WD_W  = (WD > 1) ? $clog2(WD) : 1;
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, LOCKOUT} state_t;
    logic [WD_W-1:0]   wd_q, wd_d;
`else
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
`endif

    state_t            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic              rise_q, rise_d, fall_q, fall_d;
    logic [1:0]        mode_lat_q, mode_lat_d;
    logic [CH_W-1:0]   mac_lat_q, mac_lat_d;
    logic [DIV_W-1:0]  hp_lat_q, hp_lat_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DIV_W-1:0]  per_q, per_d;
    logic              phase_q, phase_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic              led_q, led_d, busy_q, busy_d, lt_en_q, lt_en_d;

    always_comb begin
        sync_d     = {sync_q[1:0], trig};
        rise_d     = sync_q[1] & ~sync_q[2];
        fall_d     = ~sync_q[1] & sync_q[2];
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        mac_lat_d  = mac_lat_q;
        hp_lat_d   = hp_lat_q;
        dly_d      = dly_q;
        per_d      = per_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        led_d      = led_q;
`ifdef LOCTAG_WATCHDOG_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    mode_lat_d = mode;
                    mac_lat_d  = mac_q;
                    hp_lat_d   = half_period;
                    dly_d      = DLY_W'(D - 1);
                    state_d    = DELAY;
                end
            end
            DELAY: begin
                if (fall_q) begin
                    state_d = IDLE;
                end else if (dly_q == '0) begin
                    state_d = ACTIVE;
                    per_d   = hp_lat_q;
                    phase_d = 1'b1;
                    ptr_d   = '0;
`ifdef LOCTAG_WATCHDOG_EN
                    wd_d    = WD_W'(WD - 1);
`endif
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ACTIVE: begin
                // fall has priority over both period and watchdog expiry
                if (fall_q) begin
                    state_d = IDLE;
                    led_d   = ~led_q;
                end
`ifdef LOCTAG_WATCHDOG_EN
                else if (wd_q == '0) begin
                    state_d = LOCKOUT;
                    led_d   = 1'b1;
                end
`endif
                else begin
                    if (per_q == '0) begin
                        per_d   = hp_lat_q;
                        phase_d = ~phase_q;
                        ptr_d   = (ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
                    end else begin
                        per_d = per_q - 1'b1;
                    end
`ifdef LOCTAG_WATCHDOG_EN
                    wd_d = wd_q - 1'b1;
`endif
                end
            end
`ifdef LOCTAG_WATCHDOG_EN
            LOCKOUT: begin
                if (fall_q) begin
                    state_d = IDLE;
                    led_d   = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // outputs are registered from the next-state view so they line up with the state flop
        busy_d  = (state_d != IDLE);
        lt_en_d = (state_d == DELAY) || (state_d == ACTIVE);
        ctrl_d  = '0;
        if (state_d == ACTIVE) begin
            case (mode_lat_q)
                2'b01:   ctrl_d = (int'(mac_lat_q) < NUM_CH) ? (NUM_CH'(1'b1) << mac_lat_q) : '0;
                2'b10:   ctrl_d = (int'(mac_lat_q) < NUM_CH) ? (NUM_CH'(phase_d) << mac_lat_q) : '0;
                2'b11:   ctrl_d = NUM_CH'(1'b1) << ptr_d;
                default: ctrl_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            mode_lat_q <= '0;
            mac_lat_q  <= '0;
            hp_lat_q   <= '0;
            dly_q      <= '0;
            per_q      <= '0;
            phase_q    <= 1'b0;
            ptr_q      <= '0;
            ctrl_q     <= '0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            lt_en_q    <= 1'b0;
`ifdef LOCTAG_WATCHDOG_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mode_lat_q <= mode_lat_d;
            mac_lat_q  <= mac_lat_d;
            hp_lat_q   <= hp_lat_d;
            dly_q      <= dly_d;
            per_q      <= per_d;
            phase_q    <= phase_d;
            ptr_q      <= ptr_d;
            ctrl_q     <= ctrl_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            lt_en_q    <= lt_en_d;
`ifdef LOCTAG_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign ctrl      = ctrl_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign lt5534_en = lt_en_q;

endmodule
